// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader is the slave: it consumes bytes and drives the write port.
interface instr_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction memory from BASE_ADDR upward, and holds the CPU
// in reset until the requested number of words has been written.
module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LEN_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic [LEN_W-1:0] load_len,
  instr_loader_if.slave    bus,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_cnt;
  logic [LEN_W-1:0] word_cnt_inc;
  logic [1:0]       byte_cnt;
  logic [31:0]      word_q;
  logic [31:0]      addr_q;
  logic             start_ok;
  logic             handshake;

  // A new load is only accepted while no load is in progress.
  assign start_ok     = load_start && ((state == IDLE) || (state == DONE));
  // byte_ready is decoded from state alone, so byte_valid never feeds it.
  assign handshake    = (state == RECV) && bus.byte_valid;
  assign word_cnt_inc = word_cnt + LEN_W'(1);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (load_start) state_nxt = (load_len == '0) ? DONE : RECV;
      end
      RECV: begin
        if (bus.byte_valid && (byte_cnt == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = (word_cnt_inc == len_q) ? DONE : RECV;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load length, counters, word assembly and write address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      word_q   <= '0;
      addr_q   <= BASE_ADDR;
    end else if (start_ok) begin
      len_q    <= load_len;
      word_cnt <= '0;
      byte_cnt <= '0;
      addr_q   <= BASE_ADDR;
    end else if (handshake) begin
      unique case (byte_cnt)
        2'd0: word_q[7:0]   <= bus.byte_in;
        2'd1: word_q[15:8]  <= bus.byte_in;
        2'd2: word_q[23:16] <= bus.byte_in;
        2'd3: word_q[31:24] <= bus.byte_in;
        default: ;
      endcase
      byte_cnt <= byte_cnt + 2'd1;
    end else if (state == WRITE) begin
      word_cnt <= word_cnt_inc;
      byte_cnt <= '0;
      addr_q   <= addr_q + 32'd4;  // wraps modulo 2^32
    end
  end

  // Outputs are pure decodes of state or straight register copies.
  assign bus.byte_ready = (state == RECV);
  assign bus.imem_we    = (state == WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word_q;
  assign busy           = (state == RECV) || (state == WRITE);
  assign done           = (state == DONE);
  assign cpu_reset      = (state != DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: the stimulus pushes the expected
// memory writes into a scoreboard queue, a separate monitor pops and compares
// them whenever the loader strobes imem_we.
module tb_instr_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic [7:0] load_len;
  logic       cpu_reset;
  logic       busy;
  logic       done;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  instr_loader_if lif ();

  instr_loader #(.BASE_ADDR(BASE), .LEN_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .bus        (lif.slave),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!reset && lif.imem_we) begin
      check("write_busy", 32'(busy), 32'd1);
      check("write_no_ready", 32'(lif.byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: actual addr=%h data=%h required no write",
                 lif.imem_addr, lif.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", lif.imem_addr, e.addr);
        check("write_data", lif.imem_wdata, e.data);
      end
    end
  end

  // Reference model: consecutive groups of four bytes form one word, least
  // significant byte first, written at consecutive word addresses.
  task automatic push_words(input bq_t bytes, input int len);
    wr_t e;
    for (int i = 0; i < len; i++) begin
      e.addr = BASE + 32'(4 * i);
      e.data = 32'(bytes[4*i]) + (32'(bytes[4*i+1]) * 256) +
               (32'(bytes[4*i+2]) * 65536) + (32'(bytes[4*i+3]) * 16777216);
      exp_q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the start edge.
  // A garbage byte is offered during the start cycle and must be ignored.
  task automatic start_load(input logic [7:0] len);
    load_start     = 1'b1;
    load_len       = len;
    lif.byte_valid = 1'b1;
    lif.byte_in    = 8'hEE;
    @(posedge clk);
    #1;
    load_start     = 1'b0;
    lif.byte_valid = 1'b0;
  endtask

  // Called at posedge+1; offers one byte after 'gap' idle cycles and returns
  // at posedge+1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit inject);
    bit ok;
    repeat (gap) begin
      lif.byte_valid = 1'b0;
      lif.byte_in    = 8'($urandom);
      @(posedge clk);
      #1;
    end
    lif.byte_in    = b;
    lif.byte_valid = 1'b1;
    if (inject) begin
      load_start = 1'b1;
      load_len   = 8'($urandom_range(1, 200));
    end
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      check("busy_during_load", 32'(busy), 32'd1);
      check("cpu_held_during_load", 32'(cpu_reset), 32'd1);
      check("not_done_during_load", 32'(done), 32'd0);
      if (lif.byte_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_ready_timeout: actual ready=0 for 20 cycles required ready=1");
    end
    @(posedge clk);
    #1;
    lif.byte_valid = 1'b0;
    lif.byte_in    = 8'($urandom);
    load_start     = 1'b0;
  endtask

  // Full load of 'len' words; returns at posedge+1 while in DONE.
  task automatic run_load(input bq_t bytes, input int len, input int gap_max,
                          input bit fixed_gap, input bit inject);
    int gap;
    push_words(bytes, len);
    start_load(8'(len));
    if (len == 0) begin
      @(negedge clk);
      check("len0_done", 32'(done), 32'd1);
      check("len0_cpu_released", 32'(cpu_reset), 32'd0);
      check("len0_not_busy", 32'(busy), 32'd0);
      check("len0_addr", lif.imem_addr, BASE);
    end else begin
      for (int k = 0; k < 4 * len; k++) begin
        gap = fixed_gap ? gap_max : int'($urandom_range(0, gap_max));
        send_byte(bytes[k], gap, inject && (k == 1));
      end
      @(negedge clk);
      check("last_write_strobe", 32'(lif.imem_we), 32'd1);
      check("write_cycle_not_done", 32'(done), 32'd0);
      @(negedge clk);
      check("done_after_write", 32'(done), 32'd1);
      check("cpu_released", 32'(cpu_reset), 32'd0);
      check("done_not_busy", 32'(busy), 32'd0);
      check("done_not_ready", 32'(lif.byte_ready), 32'd0);
      check("done_next_addr", lif.imem_addr, BASE + 32'(4 * len));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ready"}, 32'(lif.byte_ready), 32'd0);
    check({tag, "_we"}, 32'(lif.imem_we), 32'd0);
    check({tag, "_addr"}, lif.imem_addr, BASE);
  endtask

  function automatic bq_t rand_bytes(input int len);
    bq_t q;
    for (int i = 0; i < 4 * len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t b;
    int  len;

    reset          = 1'b1;
    load_start     = 1'b0;
    load_len       = '0;
    lif.byte_valid = 1'b0;
    lif.byte_in    = '0;
    #1;
    check_idle("reset");
    #20;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle("idle_after_reset");
    end
    @(posedge clk);
    #1;

    // Single word 13 05 00 00 on consecutive cycles -> 32'h0000_0513 at addr 0.
    b = '{8'h13, 8'h05, 8'h00, 8'h00};
    run_load(b, 1, 0, 1'b1, 1'b0);

    // Three words, byte_valid toggling every other cycle.
    run_load(rand_bytes(3), 3, 1, 1'b1, 1'b0);

    // Zero-length load: straight to DONE, no write.
    b = {};
    run_load(b, 0, 0, 1'b1, 1'b0);

    // Restart from DONE with one word.
    run_load(rand_bytes(1), 1, 0, 1'b1, 1'b0);

    // load_start during RECV is ignored; original length governs.
    run_load(rand_bytes(2), 2, 1, 1'b0, 1'b1);

    // Reset after two bytes of word 1 of a two-word load.
    b = rand_bytes(2);
    push_words(b, 2);
    start_load(8'd2);
    for (int k = 0; k < 6; k++) send_byte(b[k], 0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_idle("mid_load_reset");
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle("idle_after_abort");
    end
    @(posedge clk);
    #1;
    run_load(rand_bytes(1), 1, 0, 1'b1, 1'b0);

    // Random lengths and random byte gaps.
    for (int n = 0; n < 8; n++) begin
      len = int'($urandom_range(0, 5));
      run_load(rand_bytes(len), len, 3, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
Parameters
REQ-001 The block SHALL take parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first instruction word written.
REQ-002 The block SHALL take parameter LEN_W, default 8, meaning the width of the word-count input.

Ports
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port load_start  input  1  one-cycle pulse that begins a program load.
REQ-006 The block SHALL have port load_len  input  LEN_W  the number of 32-bit words to load, sampled on the accepted load_start.
REQ-007 The block SHALL have port byte_in  input  8  the program byte stream.
REQ-008 The block SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-009 The block SHALL have port byte_ready  output  1  the loader accepts a byte this cycle.
REQ-010 The block SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-011 The block SHALL have port imem_addr  output  32  instruction-memory byte address, word-aligned.
REQ-012 The block SHALL have port imem_wdata  output  32  instruction word to be written.
REQ-013 The block SHALL have port cpu_reset  output  1  reset to the downstream datapath/CU; high while it is held off.
REQ-014 The block SHALL have port busy  output  1  a load is in progress.
REQ-015 The block SHALL have port done  output  1  the last load completed; the CPU is released.

Function
REQ-016 The block SHALL implement the FSM states IDLE, RECV, WRITE and DONE.
REQ-017 IDLE: byte_ready=0, imem_we=0, cpu_reset=1, busy=0, done=0; load_start with load_len!=0 -> RECV; load_start with load_len==0 -> DONE next cycle, with no write.
REQ-018 RECV: byte_ready=1, busy=1; a handshake occurs only when byte_valid && byte_ready, and bytes are captured little-endian (byte 0 -> bits [7:0], byte 3 -> bits [31:24]).
REQ-019 On the 4th handshake of a word, the block SHALL move to WRITE in the next cycle; byte_valid with byte_ready=0 is ignored and not buffered.
REQ-020 WRITE lasts exactly one cycle: imem_we=1, imem_wdata=assembled word, imem_addr=BASE_ADDR+4*word_cnt, byte_ready=0, busy=1.
REQ-021 Leaving WRITE, word_cnt SHALL increment; if the new word_cnt==load_len -> DONE, else -> RECV with the byte counter cleared.
REQ-022 The minimum cost SHALL be 5 cycles per word (4 RECV + 1 WRITE).
REQ-023 DONE: cpu_reset=0, done=1, busy=0, byte_ready=0, imem_we=0.
REQ-024 load_start in DONE SHALL begin a new load: done drops and cpu_reset rises in the next cycle, with the same rules as IDLE.
REQ-025 load_start while busy SHALL be ignored; load_len is not resampled.
REQ-026 imem_addr SHALL be computed modulo 2^32; wrap-around past 32'hFFFF_FFFC is permitted and not flagged.
REQ-027 Outside WRITE, imem_addr SHALL hold the next address to be written, and imem_wdata is don't-care.
REQ-028 The word counter SHALL be LEN_W bits wide, with no overflow beyond load_len.
REQ-029 All outputs SHALL be registered or decoded from state only; there is no combinational path from byte_valid to byte_ready.

Reset
REQ-030 While reset=1, the block SHALL immediately (asynchronously) enter IDLE: cpu_reset=1, byte_ready=0, imem_we=0, busy=0, done=0, imem_addr=BASE_ADDR, and word and byte counters=0.
REQ-031 Reset asserted mid-load SHALL abort the load; partially assembled bytes are discarded and no further write occurs.
REQ-032 After reset deasserts, the block SHALL stay in IDLE until load_start.

Verification
REQ-033 Single word: load_start, load_len=1, then bytes 13,05,00,00 on consecutive cycles -> one imem_we pulse, addr=0, wdata=32'h0000_0513, then done=1 and cpu_reset=0 one cycle later.
REQ-034 Three words with byte_valid toggled every other cycle -> writes at addr 0, 4, 8 with correct words; no byte is lost or duplicated; busy stays high throughout.
REQ-035 load_len=0 -> no imem_we, and done=1 with cpu_reset=0 on the cycle after load_start.
REQ-036 Reset pulsed after 2 bytes of word 1 of a 2-word load -> outputs immediately return to reset values; a new load then writes word 0 at BASE_ADDR from fresh bytes.
REQ-037 load_start pulsed during RECV -> ignored; the original load_len governs; the done timing is unchanged.
REQ-038 load_start in DONE with load_len=1 -> cpu_reset=1 the next cycle, rewrite at addr 0, then release again.
